// File: rtl/counter_arbiter.sv
// Round-robin arbiter that time-shares one external down-counter among NREQ requesters.
// Each grant loads the winner's length, decrements to zero, then pulses done to the owner.
module counter_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] len,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic              cnt_latch,
    output logic [W-1:0]      cnt_in,
    output logic              cnt_dec,
    input  logic              cnt_zero
);

    localparam int unsigned N  = NREQ;
    localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [W-1:0]    len_q;

    logic            found;
    logic [PW-1:0]   win;
    logic [PW-1:0]   idx;
    logic [W-1:0]    win_len;
    logic [W-1:0]    lens [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_lens
        assign lens[g] = len[g*W +: W];
    end

    // First requesting index at or after ptr, wrapping modulo NREQ.
    always_comb begin
        int unsigned s;
        s     = 0;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            s = 32'(ptr) + k;
            if (s >= N) s = s - N;
            idx = PW'(s);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        win_len = lens[win];
    end

    // Counter strobes follow the state directly so the decrement stops on the same
    // cycle the shared counter reports zero.
    assign busy      = (state != IDLE);
    assign cnt_latch = (state == LOAD);
    assign cnt_in    = (state == LOAD) ? len_q : '0;
    assign cnt_dec   = (state == RUN) && !cnt_zero;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            len_q <= '0;
            grant <= '0;
            done  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (found) begin
                        grant      <= '0;
                        grant[win] <= 1'b1;
                        owner      <= win;
                        len_q      <= win_len;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    state <= RUN;
                end
                RUN: begin
                    if (cnt_zero) begin
                        done  <= grant;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= '0;
                    grant <= '0;
                    ptr   <= (owner == PW'(N - 1)) ? '0 : owner + PW'(1);
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with a behavioural model of the shared down-counter.
module tb_counter_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic        cnt_latch;
    logic [3:0]  cnt_in;
    logic        cnt_dec;
    logic        cnt_zero;
    logic [3:0]  count = 4'd0;

    int total  = 0;
    int passed = 0;

    counter_arbiter #(.NREQ(4), .W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .len       (len),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .cnt_latch (cnt_latch),
        .cnt_in    (cnt_in),
        .cnt_dec   (cnt_dec),
        .cnt_zero  (cnt_zero)
    );

    always #5 clock = ~clock;

    // Shared counter: load wins over decrement, decrement saturates at zero.
    always @(posedge clock) begin
        if (cnt_latch)
            count <= cnt_in;
        else if (cnt_dec && count != 4'd0)
            count <= count - 4'd1;
    end
    assign cnt_zero = (count == 4'd0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Call during the IDLE cycle t in which the request is visible; returns in the
    // DONE cycle t+3+L after checking the whole service timeline.
    task automatic serve(input string tag, input int owner, input int l, input bit perturb);
        logic [3:0] oh;
        int decs;
        int spurious;
        oh = 4'b0001 << owner;
        tick();
        check({tag, ".grant"}, 32'(grant), 32'(oh));
        check({tag, ".latch"}, 32'(cnt_latch), 32'd1);
        check({tag, ".cnt_in"}, 32'(cnt_in), 32'(l));
        check({tag, ".busy"}, 32'(busy), 32'd1);
        decs = 0;
        spurious = 0;
        for (int i = 0; i <= l; i++) begin
            tick();
            if (i == 0 && perturb) begin
                req = '0;
                len = '1;
            end
            if (cnt_dec) decs++;
            if (done != 4'b0 || grant != oh || cnt_latch) spurious++;
        end
        check({tag, ".dec_cycles"}, 32'(decs), 32'(l));
        check({tag, ".run_glitch"}, 32'(spurious), 32'd0);
        tick();
        check({tag, ".done"}, 32'(done), 32'(oh));
        check({tag, ".grant_at_done"}, 32'(grant), 32'(oh));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".idle_grant"}, 32'(grant), 32'd0);
        check({tag, ".idle_done"}, 32'(done), 32'd0);
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        len   = '0;
        tick();
        tick();
        reset = 1'b0;
        expect_idle("reset");
        check("reset.latch", 32'(cnt_latch), 32'd0);
        check("reset.dec", 32'(cnt_dec), 32'd0);
        check("reset.cnt_in", 32'(cnt_in), 32'd0);

        // Single request, length 3; ptr moves to 1.
        req = 4'b0001;
        len = 16'h0003;
        serve("single", 0, 3, 1'b0);
        req = '0;
        tick();
        expect_idle("single");

        // Zero length: no decrement at all; ptr moves to 2.
        req = 4'b0010;
        len = 16'h0000;
        serve("zero", 1, 0, 1'b0);
        req = '0;
        tick();
        expect_idle("zero");

        // Maximum length: search from 2 wraps to requester 0; ptr moves to 1.
        req = 4'b0001;
        len = 16'h000F;
        serve("maxlen", 0, 15, 1'b0);
        req = '0;
        tick();
        expect_idle("maxlen");

        // Owner drops req and changes len during RUN; ptr moves to 3.
        req = 4'b0100;
        len = 16'h0500;
        serve("midchg", 2, 5, 1'b1);
        req = '0;
        len = '0;
        tick();
        expect_idle("midchg");

        // All requesting, length 1: rotation starts at ptr 3, one IDLE gap between services.
        req = 4'b1111;
        len = 16'h1111;
        for (int k = 0; k < 6; k++) begin
            serve($sformatf("rr%0d", k), (3 + k) % 4, 1, 1'b0);
            tick();
            expect_idle($sformatf("rr%0d", k));
        end

        // ptr is now 1: requester 1 wins, then reset lands mid-RUN.
        len = 16'h5555;
        tick();
        check("rst.grant_before", 32'(grant), 32'b0010);
        tick();
        tick();
        check("rst.dec_before", 32'(cnt_dec), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_idle("rst");
        check("rst.latch", 32'(cnt_latch), 32'd0);
        check("rst.dec", 32'(cnt_dec), 32'd0);
        check("rst.cnt_in", 32'(cnt_in), 32'd0);
        serve("postrst", 0, 5, 1'b0);
        req = '0;
        tick();
        expect_idle("postrst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
